regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port (rdwr/addr3/data3) among NREQ writeback requesters, e.g. ALU result, load result and link-register writes.
- Grants at most one write per cycle and registers it onto the write port for exactly one cycle.
- Outputs change on posedge clk, so they are stable when the register file samples them on negedge.
- Also counts same-address collisions for debug.

---
 rtl/regfile_wr_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: one registered write per cycle from NREQ requesters.
// Define RF_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, requester 0 highest.
module regfile_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    hold,
    output logic                    rf_rdwr,
    output logic [AW-1:0]           rf_addr3,
    output logic [DW-1:0]           rf_data3,
    output logic [$clog2(NREQ)-1:0] last_grant,
    output logic [7:0]              conflict_cnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW:0]   idx_w;
    logic          any_valid;
    logic          grant_en;
    logic          collide;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        gidx      = '0;
        any_valid = 1'b0;
        idx_w     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, ptr} + (PW+1)'(k);
            if (idx_w >= (PW+1)'(NREQ))
                idx_w = idx_w - (PW+1)'(NREQ);
            if (!any_valid && req_valid[idx_w[PW-1:0]]) begin
                any_valid = 1'b1;
                gidx      = idx_w[PW-1:0];
            end
        end
    end

    assign grant_en = any_valid && !hold && rst_n;

    always_comb begin
        req_ready = '0;
        if (grant_en)
            req_ready[gidx] = 1'b1;
    end

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (req_valid[i] && req_valid[j] &&
                    req_addr[i*AW +: AW] == req_addr[j*AW +: AW])
                    collide = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_rdwr      <= 1'b0;
            rf_addr3     <= '0;
            rf_data3     <= '0;
            last_grant   <= '0;
            conflict_cnt <= '0;
        end else begin
            rf_rdwr <= grant_en;
            if (grant_en) begin
                rf_addr3   <= req_addr[int'(gidx)*AW +: AW];
                rf_data3   <= req_data[int'(gidx)*DW +: DW];
                last_grant <= gidx;
                if (collide && conflict_cnt != 8'hFF)
                    conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

`ifdef RF_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (grant_en)
            ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
    end
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter (NREQ=4, AW=5, DW=32).
// Expected grant order follows RF_ARB_RR_EN when the bench is built with it.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            g;
        int            cyc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              hold;
    logic              rf_rdwr;
    logic [AW-1:0]     rf_addr3;
    logic [DW-1:0]     rf_data3;
    logic [1:0]        last_grant;
    logic [7:0]        conflict_cnt;

    logic [AW-1:0] a [NREQ];
    logic [DW-1:0] d [NREQ];
    exp_t          sb [$];
    int            cyc;
    int            n_chk;
    int            n_fail;

    regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .hold         (hold),
        .rf_rdwr      (rf_rdwr),
        .rf_addr3     (rf_addr3),
        .rf_data3     (rf_data3),
        .last_grant   (last_grant),
        .conflict_cnt (conflict_cnt)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*DW +: DW] = d[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write on the port must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rf_rdwr) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(rf_addr3), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rf_addr3", 64'(rf_addr3), 64'(e.a));
                check("rf_data3", 64'(rf_data3), 64'(e.d));
                check("last_grant", 64'(last_grant), 64'(e.g));
                check("write_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // One cycle of stimulus; g is the hand-computed winner, -1 for none.
    task automatic step(input logic [3:0] v, input logic h, input int g);
        logic [3:0] one;
        logic [3:0] exp_rdy;
        one = 4'b0001;
        req_valid = v;
        hold = h;
        #1;
        exp_rdy = (g < 0) ? 4'b0000 : (one << g);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (g >= 0)
            sb.push_back('{a[g], d[g], g, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_seq [5];
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        hold = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = AW'(i + 16);
            d[i] = DW'(32'h1000 + i);
        end
        #1;
        check("rst_rdwr", 64'(rf_rdwr), 64'd0);
        check("rst_addr", 64'(rf_addr3), 64'd0);
        check("rst_data", 64'(rf_data3), 64'd0);
        check("rst_last", 64'(last_grant), 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester
        a[1] = 5'd7;
        d[1] = 32'h0000_00AA;
        step(4'b0010, 1'b0, 1);
        step(4'b0000, 1'b0, -1);
        check("single_rdwr_drop", 64'(rf_rdwr), 64'd0);
        check("single_last", 64'(last_grant), 64'd1);

        // Reset while a write sits on the port
        req_valid = 4'b0100;
        #1;
        check("pre_rst_ready", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        check("pre_rst_rdwr", 64'(rf_rdwr), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_rdwr", 64'(rf_rdwr), 64'd0);
        check("async_rst_last", 64'(last_grant), 64'd0);
        check("async_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four requesting continuously
`ifdef RF_ARB_RR_EN
        rr_seq = '{0, 1, 2, 3, 0};
`else
        rr_seq = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++)
            step(4'b1111, 1'b0, rr_seq[i]);
        step(4'b1110, 1'b0, 1);
        step(4'b0000, 1'b0, -1);

        // hold freezes arbitration
        for (int i = 0; i < 3; i++) begin
            step(4'b1000, 1'b1, -1);
            check("hold_rdwr", 64'(rf_rdwr), 64'd0);
        end
        step(4'b1000, 1'b0, 3);
        check("after_hold_rdwr", 64'(rf_rdwr), 64'd1);
        step(4'b0000, 1'b0, -1);

        // Same-address collision
        a[0] = 5'd5;
        d[0] = 32'd11;
        a[2] = 5'd5;
        d[2] = 32'd22;
        check("cnt_before", 64'(conflict_cnt), 64'd0);
        step(4'b0101, 1'b0, 0);
        check("cnt_first", 64'(conflict_cnt), 64'd1);
        step(4'b0100, 1'b0, 2);
        check("cnt_no_collide", 64'(conflict_cnt), 64'd1);

        // Saturation: 300 more colliding grants
        for (int i = 0; i < 300; i++) begin
`ifdef RF_ARB_RR_EN
            step(4'b0101, 1'b0, (i % 2 == 0) ? 0 : 2);
`else
            step(4'b0101, 1'b0, 0);
`endif
        end
        step(4'b0000, 1'b0, -1);
        step(4'b0000, 1'b0, -1);
        check("cnt_saturated", 64'(conflict_cnt), 64'd255);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
